// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Also detects load-use hazards and handles stall, flush and bubble insertion.
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [IDX_W-1:0]  in_rs_idx,
    input  logic [IDX_W-1:0]  in_rt_idx,
    input  logic [IDX_W-1:0]  in_rd_idx,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              exmem_reg_write,
    input  logic [IDX_W-1:0]  exmem_rd_idx,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [IDX_W-1:0]  memwb_rd_idx,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_first,
    output logic [DATA_W-1:0] alu_second,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [IDX_W-1:0]  ex_rd_idx,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic              load_use_stall
);

    localparam logic [3:0]       OpZero  = 4'b1000;
    localparam logic [IDX_W-1:0] NoReg   = {IDX_W{1'b1}};

    logic              valid_q,     valid_d;
    logic [3:0]        op_q,        op_d;
    logic [DATA_W-1:0] rs_val_q,    rs_val_d;
    logic [DATA_W-1:0] rt_val_q,    rt_val_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic              use_imm_q,   use_imm_d;
    logic [IDX_W-1:0]  rs_idx_q,    rs_idx_d;
    logic [IDX_W-1:0]  rt_idx_q,    rt_idx_d;
    logic [IDX_W-1:0]  rd_idx_q,    rd_idx_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              hazard_match;
    logic              load_bubble;

    // A load in EX cannot supply its data until it reaches MEM/WB.
    always_comb begin
        hazard_match   = (rd_idx_q == in_rs_idx) || (rd_idx_q == in_rt_idx);
        load_use_stall = in_valid && valid_q && mem_read_q && (rd_idx_q != NoReg) &&
                         hazard_match && !flush;
    end

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rs_idx_d    = rs_idx_q;
        rt_idx_d    = rt_idx_q;
        rd_idx_d    = rd_idx_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        load_bubble = 1'b0;

        if (rst || flush) begin
            load_bubble = 1'b1;
        end else if (stall) begin
            load_bubble = 1'b0;
        end else if (load_use_stall || !in_valid) begin
            load_bubble = 1'b1;
        end else begin
            valid_d     = 1'b1;
            op_d        = in_op;
            rs_val_d    = in_rs_val;
            rt_val_d    = in_rt_val;
            imm_d       = in_imm;
            use_imm_d   = in_use_imm;
            rs_idx_d    = in_rs_idx;
            rt_idx_d    = in_rt_idx;
            rd_idx_d    = in_rd_idx;
            reg_write_d = in_reg_write;
            mem_read_d  = in_mem_read;
            mem_write_d = in_mem_write;
        end

        if (load_bubble) begin
            valid_d     = 1'b0;
            op_d        = OpZero;
            rs_val_d    = '0;
            rt_val_d    = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            rs_idx_d    = NoReg;
            rt_idx_d    = NoReg;
            rd_idx_d    = NoReg;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        op_q        <= op_d;
        rs_val_q    <= rs_val_d;
        rt_val_q    <= rt_val_d;
        imm_q       <= imm_d;
        use_imm_q   <= use_imm_d;
        rs_idx_q    <= rs_idx_d;
        rt_idx_q    <= rt_idx_d;
        rd_idx_q    <= rd_idx_d;
        reg_write_q <= reg_write_d;
        mem_read_q  <= mem_read_d;
        mem_write_q <= mem_write_d;
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        if ((rs_idx_q != NoReg) && exmem_reg_write && (exmem_rd_idx == rs_idx_q)) begin
            fwd_rs = exmem_result;
        end else if ((rs_idx_q != NoReg) && memwb_reg_write && (memwb_rd_idx == rs_idx_q)) begin
            fwd_rs = memwb_result;
        end else begin
            fwd_rs = rs_val_q;
        end

        if ((rt_idx_q != NoReg) && exmem_reg_write && (exmem_rd_idx == rt_idx_q)) begin
            fwd_rt = exmem_result;
        end else if ((rt_idx_q != NoReg) && memwb_reg_write && (memwb_rd_idx == rt_idx_q)) begin
            fwd_rt = memwb_result;
        end else begin
            fwd_rt = rt_val_q;
        end
    end

    always_comb begin
        alu_first     = fwd_rs;
        alu_second    = use_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_op        = op_q;
        ex_rd_idx     = rd_idx_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_valid      = valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expectations are queued when
// stimulus is driven and popped as each output is checked.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [3:0]  in_op;
    logic [15:0] in_rs_val, in_rt_val, in_imm;
    logic        in_use_imm;
    logic [3:0]  in_rs_idx, in_rt_idx, in_rd_idx;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [3:0]  exmem_rd_idx, memwb_rd_idx;
    logic [15:0] exmem_result, memwb_result;
    logic [15:0] alu_first, alu_second, ex_store_data;
    logic [3:0]  alu_op, ex_rd_idx;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, load_use_stall;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    id_ex_stage #(.DATA_W(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
        .in_rd_idx(in_rd_idx), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .exmem_reg_write(exmem_reg_write),
        .exmem_rd_idx(exmem_rd_idx), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_idx(memwb_rd_idx),
        .memwb_result(memwb_result), .alu_first(alu_first), .alu_second(alu_second),
        .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd_idx(ex_rd_idx),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_valid(ex_valid), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                               input logic [3:0] rd, input logic [15:0] rsv,
                               input logic [15:0] rtv, input logic mr);
        in_valid     = 1'b1;
        in_op        = op;
        in_rs_idx    = rs;
        in_rt_idx    = rt;
        in_rd_idx    = rd;
        in_rs_val    = rsv;
        in_rt_val    = rtv;
        in_imm       = 16'h0000;
        in_use_imm   = 1'b0;
        in_reg_write = 1'b1;
        in_mem_read  = mr;
        in_mem_write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_instr(4'h0, 4'hF, 4'hF, 4'hF, 16'h0, 16'h0, 1'b0);
        in_valid = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd_idx = 4'hF; exmem_result = 16'h0;
        memwb_reg_write = 1'b0; memwb_rd_idx = 4'hF; memwb_result = 16'h0;

        // Reset state
        expect_val("rst_valid", 16'h0); expect_val("rst_op", 16'h8);
        expect_val("rst_first", 16'h0); expect_val("rst_second", 16'h0);
        expect_val("rst_lus", 16'h0); expect_val("rst_rd", 16'hF);
        step(); step();
        rst = 1'b0;
        step();
        chk({15'h0, ex_valid}); chk({12'h0, alu_op}); chk(alu_first); chk(alu_second);
        chk({15'h0, load_use_stall}); chk({12'h0, ex_rd_idx});

        // Plain ADD, no forwarding
        drive_instr(4'h0, 4'h1, 4'h2, 4'h5, 16'h0005, 16'h0003, 1'b0);
        expect_val("add_first", 16'h0005); expect_val("add_second", 16'h0003);
        expect_val("add_op", 16'h0); expect_val("add_valid", 16'h1);
        step();
        chk(alu_first); chk(alu_second); chk({12'h0, alu_op}); chk({15'h0, ex_valid});

        // Forwarding priority on rs=3
        drive_instr(4'h1, 4'h3, 4'h7, 4'h6, 16'h0777, 16'h0000, 1'b0);
        step();
        exmem_reg_write = 1'b1; exmem_rd_idx = 4'h3; exmem_result = 16'h1111;
        memwb_reg_write = 1'b1; memwb_rd_idx = 4'h3; memwb_result = 16'h2222;
        expect_val("fwd_exmem", 16'h1111);
        #1 chk(alu_first);
        exmem_reg_write = 1'b0;
        expect_val("fwd_memwb", 16'h2222);
        #1 chk(alu_first);
        memwb_reg_write = 1'b0;
        expect_val("fwd_none", 16'h0777);
        #1 chk(alu_first);

        // Load-use hazard
        drive_instr(4'h0, 4'h7, 4'h8, 4'h4, 16'h0, 16'h0, 1'b1);
        step();
        drive_instr(4'h1, 4'h4, 4'h9, 4'hA, 16'h0001, 16'h0002, 1'b0);
        expect_val("lus_hit", 16'h1);
        #1 chk({15'h0, load_use_stall});
        expect_val("lus_bubble_valid", 16'h0); expect_val("lus_bubble_op", 16'h8);
        expect_val("lus_cleared", 16'h0);
        step();
        chk({15'h0, ex_valid}); chk({12'h0, alu_op}); chk({15'h0, load_use_stall});
        memwb_reg_write = 1'b1; memwb_rd_idx = 4'h4; memwb_result = 16'hBEEF;
        expect_val("lus_latched_valid", 16'h1); expect_val("lus_latched_first", 16'hBEEF);
        expect_val("lus_latched_op", 16'h1);
        step();
        chk({15'h0, ex_valid}); chk(alu_first); chk({12'h0, alu_op});
        memwb_reg_write = 1'b0;

        // Immediate operand with forwarded store data
        drive_instr(4'h2, 4'hB, 4'h5, 4'hF, 16'h0042, 16'h0033, 1'b0);
        in_use_imm = 1'b1; in_imm = 16'hFFFE; in_reg_write = 1'b0; in_mem_write = 1'b1;
        step();
        exmem_reg_write = 1'b1; exmem_rd_idx = 4'h5; exmem_result = 16'h00AA;
        expect_val("imm_second", 16'hFFFE); expect_val("imm_store", 16'h00AA);
        expect_val("imm_first", 16'h0042);
        #1 chk(alu_second); chk(ex_store_data); chk(alu_first);

        // Stall holds contents despite new inputs
        drive_instr(4'h3, 4'h1, 4'h2, 4'h6, 16'h1234, 16'h5678, 1'b0);
        stall = 1'b1;
        expect_val("stall_second", 16'hFFFE); expect_val("stall_store", 16'h00AA);
        expect_val("stall_op", 16'h2); expect_val("stall_mem_write", 16'h1);
        step();
        chk(alu_second); chk(ex_store_data); chk({12'h0, alu_op}); chk({15'h0, ex_mem_write});

        // Stall + flush: flush wins
        flush = 1'b1;
        expect_val("sf_valid", 16'h0); expect_val("sf_op", 16'h8);
        expect_val("sf_first", 16'h0); expect_val("sf_second", 16'h0);
        expect_val("sf_store", 16'h0);
        step();
        chk({15'h0, ex_valid}); chk({12'h0, alu_op}); chk(alu_first); chk(alu_second);
        chk(ex_store_data);
        stall = 1'b0; flush = 1'b0; exmem_reg_write = 1'b0;

        // Flush masks load_use_stall; stall wins over it but it stays asserted
        drive_instr(4'h0, 4'h7, 4'h8, 4'h4, 16'h0, 16'h0, 1'b1);
        step();
        drive_instr(4'h1, 4'h9, 4'h4, 4'hA, 16'h0, 16'h0, 1'b0);
        flush = 1'b1;
        expect_val("lus_flush_masked", 16'h0);
        #1 chk({15'h0, load_use_stall});
        flush = 1'b0; stall = 1'b1;
        expect_val("lus_under_stall", 16'h1);
        #1 chk({15'h0, load_use_stall});
        expect_val("stall_lus_hold_valid", 16'h1); expect_val("stall_lus_hold_mr", 16'h1);
        step();
        chk({15'h0, ex_valid}); chk({15'h0, ex_mem_read});
        stall = 1'b0;

        // Reset overrides a valid instruction
        drive_instr(4'h4, 4'h1, 4'h2, 4'h3, 16'h0009, 16'h0008, 1'b0);
        step();
        rst = 1'b1;
        expect_val("rst2_valid", 16'h0); expect_val("rst2_op", 16'h8);
        expect_val("rst2_first", 16'h0);
        step();
        chk({15'h0, ex_valid}); chk({12'h0, alu_op}); chk(alu_first);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
